pll_lock_sequencer: RTL and testbench

- Supervises a multi-output PLL.
- Synchronises its raw locked flag and drives the PLL reset, including automatic retry on lock timeout.
- Releases per-clock-domain resets in a fixed staggered order once lock is stable.
- Sits between the PLL wrapper and the core's domain reset tree; runs on the PLL reference clock.

---
 rtl/pll_seq_pkg.sv | 30 +++
 rtl/bit_synchronizer.sv | 29 ++
 rtl/pll_lock_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types, defaults and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam int unsigned DEF_NUM_DOMAINS    = 5;
  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_RELEASE_GAP    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 1048576;
  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_RETRY_W        = 8;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit above the largest terminal count keeps every compare unambiguous.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    return $clog2(max2(max2(a, b), max2(c, d))) + 1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module bit_synchronizer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  if (SYNC_STAGES < 2) begin : g_chk_stages
    $error("bit_synchronizer: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw level through the chain; bit 0 is the metastability-exposed flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: drives the PLL reset with timeout retry, qualifies lock and
// releases the per-domain resets in a fixed staggered order.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = DEF_NUM_DOMAINS,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned RELEASE_GAP    = DEF_RELEASE_GAP,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned RETRY_W        = DEF_RETRY_W
) (
  input  logic                   i_refclk,
  input  logic                   i_rst,
  input  logic                   i_pll_locked_async,
  input  logic                   i_clear_sticky,
  output logic                   o_pll_rst,
  output logic [NUM_DOMAINS-1:0] o_domain_rst,
  output logic                   o_ready,
  output logic                   o_lock_lost_sticky,
  output logic [RETRY_W-1:0]     o_retry_count
);

  localparam int unsigned CNT_W =
      cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, RELEASE_GAP, PLL_RST_CYCLES);

  if (NUM_DOMAINS == 0) begin : g_chk_nd
    $error("pll_lock_sequencer: NUM_DOMAINS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_ss
    $error("pll_lock_sequencer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES == 0) begin : g_chk_sc
    $error("pll_lock_sequencer: STABLE_CYCLES must be >= 1");
  end
  if (RELEASE_GAP == 0) begin : g_chk_gap
    $error("pll_lock_sequencer: RELEASE_GAP must be >= 1");
  end
  if (LOCK_TIMEOUT == 0) begin : g_chk_to
    $error("pll_lock_sequencer: LOCK_TIMEOUT must be >= 1");
  end
  if (PLL_RST_CYCLES == 0) begin : g_chk_prc
    $error("pll_lock_sequencer: PLL_RST_CYCLES must be >= 1");
  end
  if (RETRY_W == 0) begin : g_chk_rw
    $error("pll_lock_sequencer: RETRY_W must be >= 1");
  end

  logic w_locked_s;

  state_e                 r_state, w_state_d;
  logic [CNT_W-1:0]       r_cnt, w_cnt_d;
  logic [NUM_DOMAINS-1:0] r_dom, w_dom_d;
  logic [RETRY_W-1:0]     r_retry, w_retry_d;
  logic                   r_pll_rst, w_pll_rst_d;
  logic                   r_ready, w_ready_d;
  logic                   r_sticky, w_sticky_d;
  logic                   w_lost_set;

  bit_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_lock_sync (
    .i_clk (i_refclk),
    .i_rst (i_rst),
    .i_d   (i_pll_locked_async),
    .o_q   (w_locked_s)
  );

  // Next-state, counter and registered-output decode.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_dom_d    = r_dom;
    w_retry_d  = r_retry;
    w_lost_set = 1'b0;

    unique case (r_state)
      PLL_RESET: begin
        if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
          w_state_d = WAIT_LOCK;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_d = STABLE;
          w_cnt_d   = '0;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_state_d = PLL_RESET;
          w_cnt_d   = '0;
          if (r_retry != '1) begin
            w_retry_d = r_retry + 1'b1;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!w_locked_s) begin
          w_state_d = WAIT_LOCK;
          w_cnt_d   = '0;
        end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          w_state_d = RELEASE;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!w_locked_s) begin
          w_state_d  = WAIT_LOCK;
          w_cnt_d    = '0;
          w_dom_d    = '1;
          w_lost_set = 1'b1;
        end else if (r_dom == '0) begin
          w_state_d = RUN;
        end else if (r_cnt == '0) begin
          // Shifting zeros in from bit 0 makes out-of-order release impossible.
          w_dom_d = r_dom << 1;
          w_cnt_d = CNT_W'(RELEASE_GAP - 1);
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      RUN: begin
        if (!w_locked_s) begin
          w_state_d  = WAIT_LOCK;
          w_cnt_d    = '0;
          w_dom_d    = '1;
          w_lost_set = 1'b1;
        end
      end
      default: begin
        w_state_d = PLL_RESET;
        w_cnt_d   = '0;
        w_dom_d   = '1;
      end
    endcase

    w_pll_rst_d = (w_state_d == PLL_RESET);
    w_ready_d   = (w_state_d == RUN);
    // A lock loss in the same cycle as a clear keeps the flag set.
    w_sticky_d  = w_lost_set ? 1'b1 : (i_clear_sticky ? 1'b0 : r_sticky);
  end

  // State and registered outputs.
  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= PLL_RESET;
      r_cnt     <= '0;
      r_dom     <= '1;
      r_retry   <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_dom     <= w_dom_d;
      r_retry   <= w_retry_d;
      r_pll_rst <= w_pll_rst_d;
      r_ready   <= w_ready_d;
      r_sticky  <= w_sticky_d;
    end
  end

  assign o_pll_rst          = r_pll_rst;
  assign o_domain_rst       = r_dom;
  assign o_ready            = r_ready;
  assign o_lock_lost_sticky = r_sticky;
  assign o_retry_count      = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomised bench for pll_lock_sequencer: a timestamp-based reference model
// predicts every output change; a monitor matches DUT output changes against it.
module tb_pll_lock_sequencer;

  localparam int ND   = 3;
  localparam int SS   = 2;
  localparam int SC   = 8;
  localparam int G    = 4;
  localparam int TO   = 64;
  localparam int PRC  = 4;
  localparam int RW   = 2;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lk  = 1'b0;
  logic          clr = 1'b0;
  logic          prst;
  logic [ND-1:0] dom;
  logic          rdy;
  logic          stk;
  logic [RW-1:0] rc;

  pll_lock_sequencer #(
    .NUM_DOMAINS    (ND),
    .SYNC_STAGES    (SS),
    .STABLE_CYCLES  (SC),
    .RELEASE_GAP    (G),
    .LOCK_TIMEOUT   (TO),
    .PLL_RST_CYCLES (PRC),
    .RETRY_W        (RW)
  ) dut (
    .i_refclk           (clk),
    .i_rst              (rst),
    .i_pll_locked_async (lk),
    .i_clear_sticky     (clr),
    .o_pll_rst          (prst),
    .o_domain_rst       (dom),
    .o_ready            (rdy),
    .o_lock_lost_sticky (stk),
    .o_retry_count      (rc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            n;
    logic          prst;
    logic [ND-1:0] dom;
    logic          rdy;
    logic          stk;
    logic [RW-1:0] rc;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t reset_ev();
    ev_t e;
    e.n = 0; e.prst = 1'b1; e.dom = '1; e.rdy = 1'b0; e.stk = 1'b0; e.rc = '0;
    return e;
  endfunction

  function automatic bit same(input ev_t a, input ev_t b);
    return (a.prst === b.prst) && (a.dom === b.dom) && (a.rdy === b.rdy) &&
           (a.stk === b.stk) && (a.rc === b.rc);
  endfunction

  // ---------------- reference model (phase + entry timestamp) ----------------
  localparam int PH_RST = 0, PH_WAIT = 1, PH_STB = 2, PH_REL = 3, PH_RUN = 4;
  int   m_ph, m_t0, m_rc;
  logic m_stk;
  ev_t  m_last;
  logic lk_hist [0:MAXC-1];
  int   drv_n;

  task automatic model_reset();
    m_ph = PH_RST; m_t0 = 0; m_rc = 0; m_stk = 1'b0; m_last = reset_ev(); drv_n = 0;
  endtask

  // Predict outputs after edge n; push an expectation only when they change.
  task automatic model_step(input int n, input logic clr_v);
    logic s;
    logic set;
    ev_t  e;
    s   = (n > SS) ? lk_hist[n-SS] : 1'b0;
    set = 1'b0;
    case (m_ph)
      PH_RST:  if (n - m_t0 == PRC) begin m_ph = PH_WAIT; m_t0 = n; end
      PH_WAIT: begin
        if (s) begin m_ph = PH_STB; m_t0 = n; end
        else if (n - m_t0 == TO) begin
          m_ph = PH_RST; m_t0 = n;
          if (m_rc < (1 << RW) - 1) m_rc++;
        end
      end
      PH_STB: begin
        if (!s) begin m_ph = PH_WAIT; m_t0 = n; end
        else if (n - m_t0 == SC) begin m_ph = PH_REL; m_t0 = n; end
      end
      default: begin
        if (!s) begin set = 1'b1; m_ph = PH_WAIT; m_t0 = n; end
        else if (m_ph == PH_REL && n == m_t0 + 2 + (ND - 1) * G) m_ph = PH_RUN;
      end
    endcase
    m_stk = set ? 1'b1 : (clr_v ? 1'b0 : m_stk);
    e.n    = n;
    e.prst = (m_ph == PH_RST);
    e.rdy  = (m_ph == PH_RUN);
    e.stk  = m_stk;
    e.rc   = RW'(m_rc);
    for (int k = 0; k < ND; k++) begin
      if (m_ph == PH_RUN) e.dom[k] = 1'b0;
      else if (m_ph == PH_REL) e.dom[k] = (n < m_t0 + 1 + k * G);
      else e.dom[k] = 1'b1;
    end
    if (!same(e, m_last)) sb.push_back(e);
    m_last = e;
  endtask

  // ---------------- monitor ----------------
  int  mcyc;
  int  ready_rise_n;
  ev_t mon_prev, mon_cur, mon_exp;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mcyc = 0; mon_prev = reset_ev(); ready_rise_n = -1;
    end else begin
      mcyc++;
      mon_cur.n = mcyc; mon_cur.prst = prst; mon_cur.dom = dom; mon_cur.rdy = rdy;
      mon_cur.stk = stk; mon_cur.rc = rc;
      if (!same(mon_cur, mon_prev)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cycle=%0d got prst=%b dom=%b rdy=%b stk=%b rc=%0d",
                   mcyc, prst, dom, rdy, stk, rc);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_exp.n != mcyc || !same(mon_cur, mon_exp)) begin
            errors++;
            $display("FAIL output_change got cycle=%0d prst=%b dom=%b rdy=%b stk=%b rc=%0d %s",
                     mcyc, prst, dom, rdy, stk, rc, $sformatf(
                     "required cycle=%0d prst=%b dom=%b rdy=%b stk=%b rc=%0d", mon_exp.n,
                     mon_exp.prst, mon_exp.dom, mon_exp.rdy, mon_exp.stk, mon_exp.rc));
          end
        end
        if (rdy && !mon_prev.rdy) ready_rise_n = mcyc;
        mon_prev = mon_cur;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic chk_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s got=%0d pending expectations required=0 (next cycle=%0d)",
               name, sb.size(), sb[0].n);
    end
    sb.delete();
  endtask

  // Called at a falling edge; drives the inputs seen by the next rising edge.
  task automatic step(input logic lk_v, input logic clr_v);
    lk = lk_v; clr = clr_v;
    drv_n++;
    lk_hist[drv_n] = lk_v;
    model_step(drv_n, clr_v);
    @(negedge clk);
  endtask

  // Called at a falling edge; asserts rst between edges and checks it acts at once.
  task automatic reset_dut(input logic lk_v);
    #2;
    rst = 1'b1; lk = lk_v; clr = 1'b0;
    #1;
    chk_drained("drained_before_reset");
    checks++;
    if ({prst, dom, rdy, stk, rc} !== {1'b1, {ND{1'b1}}, 1'b0, 1'b0, {RW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_values got prst=%b dom=%b rdy=%b stk=%b rc=%0d required 1 %b 0 0 0",
               prst, dom, rdy, stk, rc, {ND{1'b1}});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int len;
    int left;
    logic lv;
    model_reset();
    @(negedge clk);

    // 1: clean start with lock tied high.
    reset_dut(1'b1);
    repeat (40) step(1'b1, 1'b0);
    chk("s1_ready_rise_cycle", ready_rise_n, 23);
    chk("s1_ready", int'(rdy), 1);
    chk("s1_retry", int'(rc), 0);

    // 2: no lock at all; retry counter saturates.
    reset_dut(1'b0);
    repeat (290) step(1'b0, 1'b0);
    chk("s2_retry_sat", int'(rc), 3);
    chk("s2_domains_held", int'(dom), 7);

    // 3: lock glitch during STABLE.
    reset_dut(1'b1);
    repeat (7) step(1'b1, 1'b0);
    d = $urandom_range(1, 4);
    repeat (d) step(1'b0, 1'b0);
    repeat (45) step(1'b1, 1'b0);
    chk("s3_sticky", int'(stk), 0);
    chk("s3_ready", int'(rdy), 1);

    // 4: lock loss in RUN, then relock.
    repeat (3) step(1'b0, 1'b0);
    chk("s4_domains_reasserted", int'(dom), 7);
    chk("s4_ready_low", int'(rdy), 0);
    chk("s4_no_pll_rst", int'(prst), 0);
    d = $urandom_range(0, 3);
    repeat (d) step(1'b0, 1'b0);
    repeat (40) step(1'b1, 1'b0);
    chk("s4_sticky_kept", int'(stk), 1);
    chk("s4_relocked", int'(rdy), 1);

    // 5: clear alone, then clear coincident with a loss.
    step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    chk("s5_clear", int'(stk), 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("s5_set_wins", int'(stk), 1);
    repeat (3) step(1'b0, 1'b0);
    repeat (40) step(1'b1, 1'b0);

    // 6: async reset in the middle of RELEASE.
    reset_dut(1'b1);
    d = $urandom_range(1, 9);
    repeat (13 + d) step(1'b1, 1'b0);
    reset_dut(1'b1);
    repeat (40) step(1'b1, 1'b0);
    chk("s6_restart_ready_cycle", ready_rise_n, 23);

    // Random lock waveforms with occasional clears.
    for (int r = 0; r < 4; r++) begin
      reset_dut($urandom_range(0, 1) == 1);
      left = 500;
      while (left > 0) begin
        lv  = ($urandom_range(0, 3) != 0);
        len = lv ? $urandom_range(5, 60) : $urandom_range(1, 8);
        if (!lv && $urandom_range(0, 7) == 0) len = 80;
        for (int i = 0; i < len && left > 0; i++) begin
          step(lv, $urandom_range(0, 15) == 0);
          left--;
        end
      end
    end

    #2;
    chk_drained("drained_at_end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
